// File: rtl/gppcu_instr_fetch_pkg.sv
// Shared GPPCU opcode map and instruction field geometry.
// The decoder and the fetch stage both import this package.
package gppcu_instr_fetch_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP   = 5'd0,
    OPC_MOV   = 5'd1,
    OPC_ADD   = 5'd2,
    OPC_ADC   = 5'd3,
    OPC_SUB   = 5'd4,
    OPC_SBC   = 5'd5,
    OPC_AND   = 5'd6,
    OPC_OR    = 5'd7,
    OPC_XOR   = 5'd8,
    OPC_NOT   = 5'd9,
    OPC_SHL   = 5'd10,
    OPC_SHR   = 5'd11,
    OPC_CMP   = 5'd12,
    OPC_FMUL  = 5'd13,
    OPC_FDIV  = 5'd14,
    OPC_FADD  = 5'd15,
    OPC_FSUB  = 5'd16,
    OPC_FCMP  = 5'd17,
    OPC_FSQRT = 5'd18,
    OPC_LDL   = 5'd19,
    OPC_LDI   = 5'd20,
    OPC_STL   = 5'd21
  } opcode_e;

  localparam logic [OPC_W-1:0] OPC_LAST = OPC_STL;

  // Undefined opcodes reach the decoder as NOP so it never sees an unknown code.
  function automatic logic [OPC_W-1:0] issueOpcode(input logic [OPC_W-1:0] raw);
    return (raw > OPC_LAST) ? OPC_NOP : raw;
  endfunction

endpackage

// File: rtl/gppcu_instr_fetch.sv
// Instruction fetch/issue stage: reads the program from synchronous imem,
// offers each instruction to the decoder and inserts FDIV/FSQRT stall windows.
module gppcu_instr_fetch
  import gppcu_instr_fetch_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int PC_W     = 10,
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 8
) (
  input  logic                     iCLK,
  input  logic                     iACLR,
  input  logic                     iSTART,
  input  logic [PC_W-1:0]          iPROG_LEN,
  output logic [PC_W-1:0]          oIMEM_ADDR,
  output logic                     oIMEM_RD,
  input  logic [INSTR_W-1:0]       iIMEM_DATA,
  output logic [OPC_W-1:0]         oOPC,
  output logic [INSTR_W-OPC_W-1:0] oOPERANDS,
  output logic                     oVALID,
  input  logic                     iSTALL,
  output logic                     oBUSY,
  output logic                     oDONE
);

  localparam int OPER_W  = INSTR_W - OPC_W;
  localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DATA  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    FIN   = 3'd5
  } state_e;

  state_e             state;
  state_e             nextState;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    len;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   stallCnt;

  logic             loadProg;
  logic             loadIr;
  logic             incPc;
  logic             loadDiv;
  logic             loadSqrt;
  logic             doAdvance;
  logic             lastInstr;
  logic [OPC_W-1:0] irOpc;

  assign irOpc     = ir[INSTR_W-1 -: OPC_W];
  assign lastInstr = (pc == (len - PC_W'(1)));

  // NOTE: every state element uses non-blocking assignments so all registers
  // update together from the values present before the clock edge.
  always_ff @(posedge iCLK or posedge iACLR) begin
    if (iACLR) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: all outputs of this block get a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    nextState = state;
    loadProg  = 1'b0;
    loadIr    = 1'b0;
    incPc     = 1'b0;
    loadDiv   = 1'b0;
    loadSqrt  = 1'b0;
    doAdvance = 1'b0;

    unique case (state)
      IDLE: begin
        if (iSTART) begin
          loadProg  = 1'b1;
          nextState = (iPROG_LEN != '0) ? REQ : FIN;
        end
      end
      REQ:  nextState = DATA;
      DATA: begin
        loadIr    = 1'b1;
        nextState = ISSUE;
      end
      ISSUE: begin
        // Multicycle FP ops are keyed on the raw opcode; both are defined codes.
        if (!iSTALL) begin
          if (irOpc == OPC_FDIV) begin
            loadDiv   = 1'b1;
            nextState = WAIT;
          end else if (irOpc == OPC_FSQRT) begin
            loadSqrt  = 1'b1;
            nextState = WAIT;
          end else begin
            doAdvance = 1'b1;
          end
        end
      end
      WAIT: begin
        if (stallCnt == '0) doAdvance = 1'b1;
      end
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase

    if (doAdvance) begin
      if (lastInstr) begin
        nextState = FIN;
      end else begin
        incPc     = 1'b1;
        nextState = REQ;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iACLR) begin
    if (iACLR) begin
      pc       <= '0;
      len      <= '0;
      ir       <= '0;
      stallCnt <= '0;
    end else begin
      if (loadProg) begin
        len <= iPROG_LEN;
        pc  <= '0;
      end else if (incPc) begin
        pc <= pc + PC_W'(1);
      end

      if (loadIr) ir <= iIMEM_DATA;

      // Loaded with LAT-1 and left at zero, so WAIT lasts exactly LAT cycles.
      if (loadDiv)                          stallCnt <= CNT_W'(DIV_LAT - 1);
      else if (loadSqrt)                    stallCnt <= CNT_W'(SQRT_LAT - 1);
      else if (state == WAIT && stallCnt != '0) stallCnt <= stallCnt - CNT_W'(1);
    end
  end

  assign oIMEM_ADDR = pc;
  assign oIMEM_RD   = (state == REQ);
  assign oVALID     = (state == ISSUE);
  assign oBUSY      = (state != IDLE);
  assign oDONE      = (state == FIN);
  assign oOPC       = issueOpcode(irOpc);
  assign oOPERANDS  = ir[OPER_W-1:0];

endmodule
